// File: rtl/bip_datapath_ext.sv
// Accumulator datapath for a small BIP-style CPU: latches one instruction,
// optionally waits for memory data, then updates the accumulator and {Z,N,C,V} flags.
module bip_datapath_ext #(
    parameter int NB_DATA    = 16,
    parameter int NB_OPERAND = 11,
    parameter int NB_ADDR    = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_SelA,
    input  logic                  i_SelB,
    input  logic                  i_WrAcc,
    input  logic [2:0]            i_op,
    input  logic [NB_OPERAND-1:0] i_operand,
    input  logic [NB_DATA-1:0]    i_data_memory,
    input  logic                  i_mem_valid,
    output logic [NB_ADDR-1:0]    o_addr,
    output logic [NB_DATA-1:0]    o_data_memory,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [3:0]            o_flags
);

    localparam int MSB = NB_DATA - 1;

    localparam logic [1:0] SELA_MEM  = 2'b00;
    localparam logic [1:0] SELA_IMM  = 2'b01;
    localparam logic [1:0] SELA_ALU  = 2'b10;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLL1 = 3'b101;
    localparam logic [2:0] OP_SRA1 = 3'b110;
    localparam logic [2:0] OP_ADC  = 3'b111;

    // Flag bit positions within o_flags = {Z,N,C,V}
    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    // Returns {carry, overflow, result}; arithmetic wraps modulo 2^NB_DATA.
    function automatic logic [NB_DATA+1:0] alu_f(
        input logic [NB_DATA-1:0] a,
        input logic [NB_DATA-1:0] b,
        input logic [2:0]         op,
        input logic               cin
    );
        logic [NB_DATA:0]   wide;
        logic [NB_DATA-1:0] r;
        logic               c;
        logic               v;
        wide = '0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[NB_DATA-1:0];
                c    = wide[NB_DATA];
                v    = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_ADC: begin
                wide = {1'b0, a} + {1'b0, b} + {{NB_DATA{1'b0}}, cin};
                r    = wide[NB_DATA-1:0];
                c    = wide[NB_DATA];
                v    = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // No borrow out of the extended subtraction means a >= b unsigned.
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[NB_DATA-1:0];
                c    = ~wide[NB_DATA];
                v    = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLL1: begin
                r = {a[NB_DATA-2:0], 1'b0};
                c = a[MSB];
            end
            OP_SRA1: begin
                r = {a[MSB], a[NB_DATA-1:1]};
                c = a[0];
            end
            default: r = a;
        endcase
        return {c, v, r};
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              sela_q, sela_d;
    logic                    selb_q, selb_d;
    logic                    wracc_q, wracc_d;
    logic [2:0]              op_q, op_d;
    logic [NB_OPERAND-1:0]   operand_q, operand_d;
    logic [NB_DATA-1:0]      acc_q, acc_d;
    logic [3:0]              flags_q, flags_d;
    logic                    done_q, done_d;

    // Instruction in effect this cycle: live inputs in IDLE, latched copy while waiting.
    logic                    idle;
    logic [1:0]              cur_sela;
    logic                    cur_selb;
    logic                    cur_wracc;
    logic [2:0]              cur_op;
    logic [NB_OPERAND-1:0]   cur_operand;
    logic signed [NB_DATA-1:0] ext_operand;
    logic [NB_DATA-1:0]      alu_b;
    logic [NB_DATA+1:0]      alu_out;
    logic                    mem_dep;
    logic                    exec;

    assign idle        = (state_q == ST_IDLE);
    assign cur_sela    = idle ? i_SelA    : sela_q;
    assign cur_selb    = idle ? i_SelB    : selb_q;
    assign cur_wracc   = idle ? i_WrAcc   : wracc_q;
    assign cur_op      = idle ? i_op      : op_q;
    assign cur_operand = idle ? i_operand : operand_q;

    assign ext_operand = NB_DATA'($signed(cur_operand));
    assign alu_b       = cur_selb ? ext_operand : i_data_memory;
    assign alu_out     = alu_f(acc_q, alu_b, cur_op, flags_q[FC]);

    assign mem_dep = cur_wracc &&
                     ((cur_sela == SELA_MEM) || ((cur_sela == SELA_ALU) && !cur_selb));

    always_comb begin
        state_d   = state_q;
        sela_d    = sela_q;
        selb_d    = selb_q;
        wracc_d   = wracc_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        exec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sela_d    = i_SelA;
                    selb_d    = i_SelB;
                    wracc_d   = i_WrAcc;
                    op_d      = i_op;
                    operand_d = i_operand;
                    if (mem_dep) begin
                        state_d = ST_WAIT_MEM;
                    end else begin
                        exec = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (i_mem_valid) begin
                    exec    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (exec) begin
            done_d = 1'b1;
            if (cur_wracc) begin
                case (cur_sela)
                    SELA_MEM: begin
                        acc_d       = i_data_memory;
                        flags_d[FZ] = (i_data_memory == '0);
                        flags_d[FN] = i_data_memory[MSB];
                    end
                    SELA_IMM: begin
                        acc_d       = ext_operand;
                        flags_d[FZ] = (ext_operand == '0);
                        flags_d[FN] = ext_operand[MSB];
                    end
                    SELA_ALU: begin
                        acc_d       = alu_out[NB_DATA-1:0];
                        flags_d[FZ] = (alu_out[NB_DATA-1:0] == '0);
                        flags_d[FN] = alu_out[MSB];
                        flags_d[FC] = alu_out[NB_DATA+1];
                        flags_d[FV] = alu_out[NB_DATA];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register stage: all state, including an in-flight instruction, is cleared by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            sela_q    <= '0;
            selb_q    <= 1'b0;
            wracc_q   <= 1'b0;
            op_q      <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sela_q    <= sela_d;
            selb_q    <= selb_d;
            wracc_q   <= wracc_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign o_addr        = operand_q[NB_ADDR-1:0];
    assign o_data_memory = acc_q;
    assign o_busy        = (state_q == ST_WAIT_MEM);
    assign o_done        = done_q;
    assign o_flags       = flags_q;

endmodule

// File: tb/tb_bip_datapath_ext.sv
// Self-checking bench for bip_datapath_ext: directed scenarios plus randomized
// instructions compared against an arithmetic reference model.
module tb_bip_datapath_ext;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_SelA;
    logic        i_SelB;
    logic        i_WrAcc;
    logic [2:0]  i_op;
    logic [10:0] i_operand;
    logic [15:0] i_data_memory;
    logic        i_mem_valid;
    logic [10:0] o_addr;
    logic [15:0] o_data_memory;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_flags;

    int checks = 0;
    int errors = 0;

    // Reference state: accumulator as an unsigned integer 0..65535 plus flags
    int   m_acc;
    logic m_z, m_n, m_c, m_v;

    always #5 i_clk = ~i_clk;

    bip_datapath_ext #(.NB_DATA(16), .NB_OPERAND(11), .NB_ADDR(11)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_SelA(i_SelA),
        .i_SelB(i_SelB), .i_WrAcc(i_WrAcc), .i_op(i_op), .i_operand(i_operand),
        .i_data_memory(i_data_memory), .i_mem_valid(i_mem_valid), .o_addr(o_addr),
        .o_data_memory(o_data_memory), .o_busy(o_busy), .o_done(o_done), .o_flags(o_flags)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_instr(input logic [1:0] sela, input logic selb, input logic wracc,
                               input logic [2:0] op, input logic [10:0] operand);
        i_SelA    = sela;
        i_SelB    = selb;
        i_WrAcc   = wracc;
        i_op      = op;
        i_operand = operand;
        i_start   = 1'b1;
    endtask

    function automatic logic [3:0] m_flags();
        return {m_z, m_n, m_c, m_v};
    endfunction

    function automatic logic [15:0] m_acc16();
        return 16'(m_acc);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    endtask

    // Behavioural model in plain integer arithmetic over the instruction's fields.
    task automatic model_exec(input logic [1:0] sela, input logic selb, input logic wracc,
                              input logic [2:0] op, input logic [10:0] operand,
                              input logic [15:0] mem);
        int a, bb, sa, sb, ext, full, s, r, cin;
        ext = int'(operand);
        if (ext >= 1024) ext = ext - 2048 + 65536;
        if (!wracc || sela == 2'b11) return;
        r = 0;
        if (sela == 2'b00) begin
            r = int'(mem);
        end else if (sela == 2'b01) begin
            r = ext;
        end else begin
            a   = m_acc;
            bb  = selb ? ext : int'(mem);
            sa  = (a  >= 32768) ? a  - 65536 : a;
            sb  = (bb >= 32768) ? bb - 65536 : bb;
            cin = m_c ? 1 : 0;
            case (op)
                3'd0, 3'd7: begin
                    full = a + bb + ((op == 3'd7) ? cin : 0);
                    s    = sa + sb + ((op == 3'd7) ? cin : 0);
                    r    = full % 65536;
                    m_c  = (full > 65535);
                    m_v  = (s > 32767) || (s < -32768);
                end
                3'd1: begin
                    r   = (a - bb + 65536) % 65536;
                    s   = sa - sb;
                    m_c = (a >= bb);
                    m_v = (s > 32767) || (s < -32768);
                end
                3'd2: begin r = a & bb; m_c = 1'b0; m_v = 1'b0; end
                3'd3: begin r = a | bb; m_c = 1'b0; m_v = 1'b0; end
                3'd4: begin r = a ^ bb; m_c = 1'b0; m_v = 1'b0; end
                3'd5: begin r = (a * 2) % 65536; m_c = (a >= 32768); m_v = 1'b0; end
                default: begin
                    r   = a / 2 + ((a >= 32768) ? 32768 : 0);
                    m_c = ((a % 2) == 1);
                    m_v = 1'b0;
                end
            endcase
        end
        m_acc = r;
        m_z   = (r == 0);
        m_n   = (r >= 32768);
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        step();
        step();
        checks++; if (o_data_memory !== 16'h0000) begin errors++; $display("FAIL reset_acc got=%h exp=0000", o_data_memory); end
        checks++; if (o_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", o_flags); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
        checks++; if (o_addr !== 11'h000) begin errors++; $display("FAIL reset_addr got=%h exp=000", o_addr); end
        i_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_ldi();
        drive_instr(2'b01, 1'b0, 1'b1, 3'd0, 11'h7FF);
        step();
        i_start = 1'b0;
        model_exec(2'b01, 1'b0, 1'b1, 3'd0, 11'h7FF, 16'h0000);
        checks++; if (o_data_memory !== 16'hFFFF) begin errors++; $display("FAIL ldi_acc got=%h exp=FFFF", o_data_memory); end
        checks++; if (o_flags !== 4'b0100) begin errors++; $display("FAIL ldi_flags got=%b exp=0100", o_flags); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL ldi_done got=%b exp=1", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ldi_busy got=%b exp=0", o_busy); end
        step();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL ldi_done_pulse got=%b exp=0", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ldi_busy_after got=%b exp=0", o_busy); end
    endtask

    task automatic test_add_overflow_wait();
        drive_instr(2'b00, 1'b0, 1'b1, 3'd0, 11'h010);
        step();
        i_start = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ld_busy got=%b exp=1", o_busy); end
        i_mem_valid = 1'b1; i_data_memory = 16'h7FFF;
        step();
        i_mem_valid = 1'b0;
        model_exec(2'b00, 1'b0, 1'b1, 3'd0, 11'h010, 16'h7FFF);
        checks++; if (o_data_memory !== 16'h7FFF) begin errors++; $display("FAIL ld_acc got=%h exp=7FFF", o_data_memory); end
        drive_instr(2'b10, 1'b0, 1'b1, 3'd0, 11'h020);
        step();
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL add_wait busy=%b done=%b exp busy=1 done=0", o_busy, o_done); end
            step();
        end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL add_wait_hold got=%b exp=1", o_busy); end
        i_mem_valid = 1'b1; i_data_memory = 16'h0001;
        step();
        i_mem_valid = 1'b0;
        model_exec(2'b10, 1'b0, 1'b1, 3'd0, 11'h020, 16'h0001);
        checks++; if (o_data_memory !== 16'h8000) begin errors++; $display("FAIL add_acc got=%h exp=8000", o_data_memory); end
        checks++; if (o_flags !== 4'b0101) begin errors++; $display("FAIL add_flags got=%b exp=0101", o_flags); end
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL add_retire busy=%b done=%b exp busy=0 done=1", o_busy, o_done); end
        checks++; if (o_addr !== 11'h020) begin errors++; $display("FAIL add_addr got=%h exp=020", o_addr); end
    endtask

    task automatic test_sub_adc();
        drive_instr(2'b01, 1'b0, 1'b1, 3'd0, 11'd5);
        step();
        model_exec(2'b01, 1'b0, 1'b1, 3'd0, 11'd5, 16'h0000);
        checks++; if (o_data_memory !== 16'h0005 || o_flags !== 4'b0001) begin errors++; $display("FAIL ldi5 acc=%h flags=%b exp acc=0005 flags=0001", o_data_memory, o_flags); end
        drive_instr(2'b10, 1'b1, 1'b1, 3'd1, 11'd5);
        step();
        model_exec(2'b10, 1'b1, 1'b1, 3'd1, 11'd5, 16'h0000);
        checks++; if (o_data_memory !== 16'h0000) begin errors++; $display("FAIL sub_acc got=%h exp=0000", o_data_memory); end
        checks++; if (o_flags !== 4'b1010) begin errors++; $display("FAIL sub_flags got=%b exp=1010", o_flags); end
        drive_instr(2'b10, 1'b1, 1'b1, 3'd7, 11'd0);
        step();
        i_start = 1'b0;
        model_exec(2'b10, 1'b1, 1'b1, 3'd7, 11'd0, 16'h0000);
        checks++; if (o_data_memory !== 16'h0001) begin errors++; $display("FAIL adc_acc got=%h exp=0001", o_data_memory); end
        checks++; if (o_flags !== 4'b0000 || o_done !== 1'b1) begin errors++; $display("FAIL adc_flags flags=%b done=%b exp flags=0000 done=1", o_flags, o_done); end
    endtask

    task automatic test_reset_midwait();
        drive_instr(2'b01, 1'b0, 1'b1, 3'd0, 11'h123);
        step();
        drive_instr(2'b00, 1'b0, 1'b1, 3'd0, 11'h055);
        step();
        i_start = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_data_memory !== 16'h0123) begin errors++; $display("FAIL midwait_pre busy=%b acc=%h exp busy=1 acc=0123", o_busy, o_data_memory); end
        i_rst = 1'b0;
        step();
        model_reset();
        checks++; if (o_data_memory !== 16'h0000 || o_busy !== 1'b0) begin errors++; $display("FAIL midwait_rst acc=%h busy=%b exp acc=0000 busy=0", o_data_memory, o_busy); end
        checks++; if (o_flags !== 4'b0000 || o_addr !== 11'h000) begin errors++; $display("FAIL midwait_rst_regs flags=%b addr=%h exp 0000/000", o_flags, o_addr); end
        i_rst = 1'b1;
        i_mem_valid = 1'b1; i_data_memory = 16'h1234;
        step();
        step();
        i_mem_valid = 1'b0;
        checks++; if (o_data_memory !== 16'h0000 || o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL midwait_discard acc=%h done=%b busy=%b exp 0000/0/0", o_data_memory, o_done, o_busy); end
    endtask

    task automatic test_start_while_busy();
        drive_instr(2'b00, 1'b0, 1'b1, 3'd0, 11'h0AA);
        step();
        i_start = 1'b0;
        step();
        drive_instr(2'b01, 1'b0, 1'b1, 3'd0, 11'd3);
        step();
        checks++; if (o_busy !== 1'b1 || o_data_memory !== 16'h0000 || o_addr !== 11'h0AA) begin errors++; $display("FAIL busy_start busy=%b acc=%h addr=%h exp 1/0000/0AA", o_busy, o_data_memory, o_addr); end
        i_mem_valid = 1'b1; i_data_memory = 16'hBEEF;
        step();
        i_start = 1'b0; i_mem_valid = 1'b0;
        model_exec(2'b00, 1'b0, 1'b1, 3'd0, 11'h0AA, 16'hBEEF);
        checks++; if (o_data_memory !== 16'hBEEF || o_flags !== m_flags()) begin errors++; $display("FAIL busy_retire acc=%h flags=%b exp acc=BEEF flags=%b", o_data_memory, o_flags, m_flags()); end
        checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL busy_retire_ctl done=%b busy=%b exp 1/0", o_done, o_busy); end
    endtask

    task automatic test_back_to_back();
        i_mem_valid = 1'b1; i_data_memory = 16'h1111;
        drive_instr(2'b00, 1'b0, 1'b1, 3'd0, 11'h077);
        step();
        i_start = 1'b0; i_mem_valid = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_data_memory !== m_acc16()) begin errors++; $display("FAIL coincident_valid busy=%b acc=%h exp busy=1 acc=%h", o_busy, o_data_memory, m_acc16()); end
        step();
        i_mem_valid = 1'b1; i_data_memory = 16'h2222;
        step();
        i_mem_valid = 1'b0;
        model_exec(2'b00, 1'b0, 1'b1, 3'd0, 11'h077, 16'h2222);
        checks++; if (o_data_memory !== 16'h2222 || o_done !== 1'b1) begin errors++; $display("FAIL later_valid acc=%h done=%b exp 2222/1", o_data_memory, o_done); end
        drive_instr(2'b10, 1'b1, 1'b1, 3'd4, 11'h00F);
        step();
        drive_instr(2'b11, 1'b0, 1'b1, 3'd0, 11'h000);
        model_exec(2'b10, 1'b1, 1'b1, 3'd4, 11'h00F, 16'h0000);
        checks++; if (o_data_memory !== 16'h222D || o_done !== 1'b1) begin errors++; $display("FAIL b2b_xor acc=%h done=%b exp 222D/1", o_data_memory, o_done); end
        step();
        i_start = 1'b0;
        checks++; if (o_data_memory !== 16'h222D || o_done !== 1'b1 || o_flags !== m_flags()) begin errors++; $display("FAIL b2b_hold acc=%h done=%b flags=%b exp 222D/1/%b", o_data_memory, o_done, o_flags, m_flags()); end
    endtask

    task automatic test_random();
        logic [1:0]  sela;
        logic        selb, wracc, dep;
        logic [2:0]  op;
        logic [10:0] operand;
        logic [15:0] data;
        int          waits;
        for (int n = 0; n < 300; n++) begin
            sela    = 2'($urandom_range(0, 3));
            selb    = 1'($urandom_range(0, 1));
            wracc   = ($urandom_range(0, 7) != 0);
            op      = 3'($urandom_range(0, 7));
            operand = 11'($urandom);
            dep     = wracc && (sela == 2'b00 || (sela == 2'b10 && !selb));
            i_mem_valid   = 1'($urandom_range(0, 1));
            i_data_memory = 16'($urandom);
            drive_instr(sela, selb, wracc, op, operand);
            step();
            i_start = 1'b0; i_mem_valid = 1'b0;
            if (dep) begin
                waits = $urandom_range(0, 3);
                for (int k = 0; k < waits; k++) begin
                    checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL rnd_wait n=%0d busy=%b done=%b exp 1/0", n, o_busy, o_done); end
                    i_start = 1'($urandom_range(0, 1));
                    i_SelA = 2'($urandom); i_operand = 11'($urandom);
                    i_data_memory = 16'($urandom);
                    step();
                    i_start = 1'b0;
                end
                data = 16'($urandom);
                if ($urandom_range(0, 3) == 0) data = 16'h0000;
                i_mem_valid = 1'b1; i_data_memory = data;
                step();
                i_mem_valid = 1'b0;
            end else begin
                data = 16'h0000;
            end
            model_exec(sela, selb, wracc, op, operand, data);
            checks++; if (o_data_memory !== m_acc16()) begin errors++; $display("FAIL rnd_acc n=%0d sela=%b op=%0d got=%h exp=%h", n, sela, op, o_data_memory, m_acc16()); end
            checks++; if (o_flags !== m_flags()) begin errors++; $display("FAIL rnd_flags n=%0d sela=%b op=%0d got=%b exp=%b", n, sela, op, o_flags, m_flags()); end
            checks++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_addr !== operand) begin errors++; $display("FAIL rnd_ctl n=%0d done=%b busy=%b addr=%h exp 1/0/%h", n, o_done, o_busy, o_addr, operand); end
        end
    endtask

    initial begin
        i_rst = 1'b0; i_start = 1'b0; i_SelA = 2'b00; i_SelB = 1'b0; i_WrAcc = 1'b0;
        i_op = 3'd0; i_operand = 11'h000; i_data_memory = 16'h0000; i_mem_valid = 1'b0;
        model_reset();
        test_reset();
        test_ldi();
        test_add_overflow_wait();
        test_sub_adc();
        test_reset_midwait();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bip_datapath_ext.md
BIP_DATAPATH_EXT -- requirements
Module: bip_datapath_ext

Interface
REQ-001 SHALL have parameter NB_DATA, default 16, accumulator/ALU width.
REQ-002 SHALL have parameter NB_OPERAND, default 11, instruction operand width; NB_OPERAND <= NB_DATA.
REQ-003 SHALL have parameter NB_ADDR, default 11, memory address width; NB_ADDR <= NB_OPERAND.
REQ-004 SHALL have port i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_start  in  1  instruction valid; sampled only in IDLE.
REQ-007 SHALL have port i_SelA  in  2  acc source: 00 memory, 01 sign-extended operand, 10 ALU result, 11 hold.
REQ-008 SHALL have port i_SelB  in  1  ALU operand B: 0 memory, 1 sign-extended operand.
REQ-009 SHALL have port i_WrAcc  in  1  accumulator write enable.
REQ-010 SHALL have port i_op  in  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL1, 110 SRA1, 111 ADC.
REQ-011 SHALL have port i_operand  in  NB_OPERAND  immediate / address field.
REQ-012 SHALL have port i_data_memory  in  NB_DATA  memory read data.
REQ-013 SHALL have port i_mem_valid  in  1  i_data_memory valid this cycle.
REQ-014 SHALL have port o_addr  out  NB_ADDR  latched operand low bits.
REQ-015 SHALL have port o_data_memory  out  NB_DATA  accumulator value.
REQ-016 SHALL have port o_busy  out  1  high in WAIT_MEM.
REQ-017 SHALL have port o_done  out  1  one-cycle pulse after instruction retires.
REQ-018 SHALL have port o_flags  out  4  {Z,N,C,V}, registered.

Function
REQ-019 SHALL sign-extend i_operand to NB_DATA for SelA=01 and SelB=1.
REQ-020 SHALL latch i_SelA, i_SelB, i_WrAcc, i_op, i_operand on the edge i_start is accepted; o_addr = latched operand[NB_ADDR-1:0], held until next accept.
REQ-021 SHALL implement FSM IDLE/WAIT_MEM; instruction is memory-dependent when WrAcc=1 and (SelA=00 or (SelA=10 and SelB=0)).
REQ-022 SHALL, for non-memory instruction accepted in IDLE, update acc/flags on the accepting edge, stay IDLE, pulse o_done the following cycle (latency 1).
REQ-023 SHALL, for memory-dependent instruction, go IDLE->WAIT_MEM on accept; in WAIT_MEM, on the edge i_mem_valid=1, compute with that cycle's i_data_memory, write acc/flags, return IDLE, pulse o_done next cycle.
REQ-024 SHALL ignore i_mem_valid in IDLE, including when coincident with i_start; the memory instruction waits for a later i_mem_valid.
REQ-025 SHALL ignore i_start while o_busy=1; no wait timeout.
REQ-026 SHALL, for WrAcc=0 or SelA=11, leave acc and flags unchanged and still pulse o_done.
REQ-027 SHALL compute ALU modulo 2^NB_DATA, A=acc; ADC adds C flag; SLL1/SRA1 shift acc by one, ignoring B.
REQ-028 SHALL, on ALU write (SelA=10), update Z (result==0), N (result MSB), C (ADD/ADC carry-out; SUB 1 when acc>=B unsigned; SLL1 acc MSB; SRA1 acc LSB; logic ops 0), V (ADD/ADC/SUB two's-complement overflow, else 0).
REQ-029 SHALL, on load (SelA=00/01), update Z and N only; C and V held.
REQ-030 SHALL drive o_data_memory directly from the accumulator register.

Reset
REQ-031 SHALL, when i_rst=0 at a rising edge, set acc=0, o_flags=0, latched fields=0, o_addr=0, o_busy=0, o_done=0, state IDLE, regardless of state (including mid WAIT_MEM).
REQ-032 SHALL discard an instruction aborted by reset; i_mem_valid after reset has no effect.

Verification
REQ-033 SHALL cover: reset asserted 2 cycles -> o_data_memory=0, o_flags=0000, o_busy=0, o_done=0.
REQ-034 SHALL cover: LDI (SelA=01, WrAcc=1) operand 11'h7FF -> acc=16'hFFFF, Z=0 N=1 after 1 edge, o_done 1 cycle, o_busy stays 0.
REQ-035 SHALL cover: acc=16'h7FFF, ADD SelB=0, i_mem_valid low 3 cycles then high with data 1 -> o_busy high 3+ cycles, acc=16'h8000, flags Z=0 N=1 C=0 V=1.
REQ-036 SHALL cover: acc=5, SUB SelB=1 operand 5 -> acc=0, Z=1 N=0 C=1 V=0; then ADC operand 0 -> acc=1.
REQ-037 SHALL cover: reset pulled low while in WAIT_MEM -> IDLE, acc=0 next edge; subsequent i_mem_valid with data 16'h1234 leaves acc=0.
REQ-038 SHALL cover: i_start with LDI 3 while busy -> ignored; acc reflects only the pending memory instruction.
